// File: rtl/roc_pkg.sv
// Shared types and constants for the ROC inference controller and its
// event counter. The AER reset word is the same constant the encoder uses
// for its reset events.
package roc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    ENCODE = 3'd2,
    STOP   = 3'd3,
    TAIL   = 3'd4,
    RESULT = 3'd5
  } roc_ctrl_state_t;

  localparam logic [9:0] AER_RST_WORD = 10'h1FF;

  // Saturating 16-bit increment, used by the optional latency counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/roc_event_counter.sv
// Rising-edge detector on the encoder event strobe plus a saturating
// counter of pixel indices. Encoder reset words (AER_RST_WORD) are not
// pixels and are not counted. The edge register tracks the strobe every
// cycle, so a strobe that is already high when counting is enabled does
// not produce a spurious count.
module roc_event_counter
  import roc_pkg::*;
#(
  parameter int IMAGE_SIZE = 256,
  parameter int CNT_BITS   = $clog2(IMAGE_SIZE) + 1
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                clr,
  input  logic                en,
  input  logic                strobe,
  input  logic [9:0]          word,
  output logic [CNT_BITS-1:0] count
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(IMAGE_SIZE);

  logic                strobe_d_r;
  logic [CNT_BITS-1:0] count_r;
  logic                rise_s;
  logic                hit_s;

  // Qualify a counted event: enabled, rising edge, pixel word, not saturated.
  always_comb begin
    rise_s = strobe & ~strobe_d_r;
    hit_s  = 1'b0;
    if (en && rise_s && (word != AER_RST_WORD) && (count_r < CNT_MAX)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Delayed copy of the strobe for edge detection.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      strobe_d_r <= 1'b0;
    end else begin
      strobe_d_r <= strobe;
    end
  end

  // Saturating index counter, cleared when a new image is launched.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (hit_s) begin
      count_r <= count_r + CNT_BITS'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/roc_inference_ctrl.sv
// ROC inference controller: launches one encoder run per host image,
// decides the class on the first output spike, stops the encoder early
// and hands class / index count / status back to the host.
// Optional build macro: ROC_LATENCY_CNT_EN enables the 16-bit
// LAUNCH-to-RESULT latency counter on RESULT_CYCLES; without it the port
// reads 16'h0.
module roc_inference_ctrl
  import roc_pkg::*;
#(
  parameter int IMAGE_SIZE      = 256,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int LABEL_BITS      = 8,
  parameter int TIMEOUT_CYCLES  = 4096,
  parameter int TIMEOUT_BITS    = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic                       IMG_VALID,
  output logic                       IMG_READY,
  output logic                       NEW_IMAGE,
  input  logic                       ENCODER_RDY,
  input  logic                       FOUND_NEXT_INDEX,
  input  logic [9:0]                 NEXT_INDEX,
  output logic                       INFERENCE_RDY,
  input  logic                       OUT_SPIKE_VALID,
  input  logic [LABEL_BITS-1:0]      OUT_SPIKE_ID,
  output logic                       RESULT_VALID,
  input  logic                       RESULT_ACK,
  output logic [LABEL_BITS-1:0]      RESULT_LABEL,
  output logic                       RESULT_TIMEOUT,
  output logic [IMAGE_SIZE_BITS:0]   RESULT_NIDX,
  output logic [15:0]                RESULT_CYCLES
);

  localparam logic [TIMEOUT_BITS-1:0] TIMEOUT_LAST = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);

  roc_ctrl_state_t          state_r;
  logic                     new_image_r;
  logic                     inference_rdy_r;
  logic                     result_valid_r;
  logic [LABEL_BITS-1:0]    label_r;
  logic                     timeout_r;
  logic [TIMEOUT_BITS-1:0]  tcnt_r;

  logic                     launch_s;
  logic                     count_en_s;
  logic                     img_ready_s;
  logic [IMAGE_SIZE_BITS:0] nidx_s;

  // Decode the image accept, index-count enable and ready from state.
  always_comb begin
    launch_s    = 1'b0;
    count_en_s  = 1'b0;
    img_ready_s = 1'b0;
    if (state_r == IDLE) begin
      img_ready_s = ENCODER_RDY;
      launch_s    = IMG_VALID & ENCODER_RDY;
    end else begin
      img_ready_s = 1'b0;
      launch_s    = 1'b0;
    end
    if ((state_r == ENCODE) || (state_r == STOP)) begin
      count_en_s = 1'b1;
    end else begin
      count_en_s = 1'b0;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_r         <= IDLE;
      new_image_r     <= 1'b0;
      inference_rdy_r <= 1'b0;
      result_valid_r  <= 1'b0;
      label_r         <= '0;
      timeout_r       <= 1'b0;
      tcnt_r          <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (launch_s) begin
            state_r     <= LAUNCH;
            new_image_r <= 1'b1;
            tcnt_r      <= '0;
            label_r     <= '0;
            timeout_r   <= 1'b0;
          end
        end
        LAUNCH: begin
          state_r     <= ENCODE;
          new_image_r <= 1'b0;
        end
        ENCODE: begin
          if (OUT_SPIKE_VALID) begin
            label_r <= OUT_SPIKE_ID;
            if (ENCODER_RDY) begin
              // Encoder already finished: no stop request is needed.
              state_r        <= RESULT;
              result_valid_r <= 1'b1;
            end else begin
              state_r         <= STOP;
              inference_rdy_r <= 1'b1;
            end
          end else if (ENCODER_RDY) begin
            state_r <= TAIL;
          end
        end
        STOP: begin
          // Later spikes are ignored; only wait for the encoder to go idle.
          if (ENCODER_RDY) begin
            state_r         <= RESULT;
            inference_rdy_r <= 1'b0;
            result_valid_r  <= 1'b1;
          end
        end
        TAIL: begin
          tcnt_r <= tcnt_r + TIMEOUT_BITS'(1);
          // A spike on the expiry cycle takes priority over the timeout.
          if (OUT_SPIKE_VALID) begin
            state_r        <= RESULT;
            label_r        <= OUT_SPIKE_ID;
            timeout_r      <= 1'b0;
            result_valid_r <= 1'b1;
          end else if (tcnt_r == TIMEOUT_LAST) begin
            state_r        <= RESULT;
            label_r        <= '0;
            timeout_r      <= 1'b1;
            result_valid_r <= 1'b1;
          end
        end
        RESULT: begin
          if (RESULT_ACK) begin
            state_r        <= IDLE;
            result_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r         <= IDLE;
          new_image_r     <= 1'b0;
          inference_rdy_r <= 1'b0;
          result_valid_r  <= 1'b0;
          label_r         <= '0;
          timeout_r       <= 1'b0;
          tcnt_r          <= '0;
        end
      endcase
    end
  end

  roc_event_counter #(
    .IMAGE_SIZE (IMAGE_SIZE),
    .CNT_BITS   (IMAGE_SIZE_BITS + 1)
  ) u_event_counter (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .clr    (launch_s),
    .en     (count_en_s),
    .strobe (FOUND_NEXT_INDEX),
    .word   (NEXT_INDEX),
    .count  (nidx_s)
  );

`ifdef ROC_LATENCY_CNT_EN
  logic [15:0] cycles_r;

  // Latency counter: cleared on launch, runs until RESULT is entered.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cycles_r <= 16'h0;
    end else if (launch_s) begin
      cycles_r <= 16'h0;
    end else if ((state_r == LAUNCH) || (state_r == ENCODE) ||
                 (state_r == STOP)   || (state_r == TAIL)) begin
      cycles_r <= sat_inc16(cycles_r);
    end else begin
      cycles_r <= cycles_r;
    end
  end

  assign RESULT_CYCLES = cycles_r;
`else
  assign RESULT_CYCLES = 16'h0;
`endif

  assign IMG_READY      = img_ready_s;
  assign NEW_IMAGE      = new_image_r;
  assign INFERENCE_RDY  = inference_rdy_r;
  assign RESULT_VALID   = result_valid_r;
  assign RESULT_LABEL   = label_r;
  assign RESULT_TIMEOUT = timeout_r;
  assign RESULT_NIDX    = nidx_s;

endmodule

// File: doc/roc_inference_ctrl.md
Name: roc_inference_ctrl

Overview:
- Sequences one inference per image around the ROC encoder.
- Accepts an image handshake from the host and pulses the encoder's NEW_IMAGE.
- Watches the SNN core's output spikes. The first spike decides the class; the block then asserts INFERENCE_RDY to stop the encoder early.
- Returns class, index count and status to the host through a valid/ack result handshake. Sits between host/SPI glue, the encoder and the core's output AER.

Parameters:
- IMAGE_SIZE, 256, pixels per image.
- IMAGE_SIZE_BITS, $clog2(IMAGE_SIZE), pixel index width.
- LABEL_BITS, 8, output neuron address width.
- TIMEOUT_CYCLES, 4096, cycles to wait for a spike after the encoder has sent every pixel.
- TIMEOUT_BITS, $clog2(TIMEOUT_CYCLES+1), timeout counter width.

Ports:
- CLK  in  1  clock.
- RSTN  in  1  reset; asynchronous, active-low.
- IMG_VALID  in  1  host: image loaded and stable.
- IMG_READY  out  1  block can accept an image.
- NEW_IMAGE  out  1  one-cycle start pulse to the encoder.
- ENCODER_RDY  in  1  encoder is idle.
- FOUND_NEXT_INDEX  in  1  encoder event strobe.
- NEXT_INDEX  in  10  encoder AER word.
- INFERENCE_RDY  out  1  stop request to the encoder.
- OUT_SPIKE_VALID  in  1  core output spike, one cycle per event.
- OUT_SPIKE_ID  in  LABEL_BITS  spiking output neuron.
- RESULT_VALID  out  1  result held for the host.
- RESULT_ACK  in  1  host consumed the result.
- RESULT_LABEL  out  LABEL_BITS  winning neuron; 0 on timeout.
- RESULT_TIMEOUT  out  1  no spike before timeout.
- RESULT_NIDX  out  IMAGE_SIZE_BITS+1  pixel indices sent before the decision.
- RESULT_CYCLES  out  16  latency; see Optional Feature.

Behaviour:
- Reset values: all outputs 0 except IMG_READY, which follows ENCODER_RDY while in IDLE. State=IDLE, all counters 0.
- IDLE:
  - IMG_READY = ENCODER_RDY.
  - IMG_VALID & IMG_READY -> LAUNCH; clear RESULT_NIDX, the timeout counter and the cycle counter.
- LAUNCH:
  - NEW_IMAGE=1 for exactly one cycle, then -> ENCODE.
  - The encoder samples NEW_IMAGE in its idle state, so ENCODER_RDY is 0 from the first ENCODE cycle.
- ENCODE, priority top-down:
  - OUT_SPIKE_VALID: latch OUT_SPIKE_ID. If ENCODER_RDY=1 -> RESULT, else -> STOP.
  - ENCODER_RDY=1: all pixels sent -> TAIL.
- STOP:
  - INFERENCE_RDY=1, held until ENCODER_RDY=1, then -> RESULT.
  - INFERENCE_RDY deasserts in the RESULT entry cycle.
  - Further spikes are ignored.
- TAIL:
  - The timeout counter increments every cycle.
  - OUT_SPIKE_VALID -> latch ID, -> RESULT with RESULT_TIMEOUT=0.
  - Counter == TIMEOUT_CYCLES-1 with no spike -> RESULT, RESULT_TIMEOUT=1, RESULT_LABEL=0.
  - A spike in the same cycle as expiry wins (no timeout).
- RESULT:
  - RESULT_VALID=1; label, timeout flag, NIDX and CYCLES held stable.
  - RESULT_ACK -> IDLE the next cycle.
  - ACK outside RESULT is ignored.
- Index counter:
  - Rising edge of FOUND_NEXT_INDEX with NEXT_INDEX != 10'h1FF increments RESULT_NIDX. The 0x1FF words are encoder reset events and are excluded.
  - Active in ENCODE and STOP only.
  - Saturates at IMAGE_SIZE.
  - The edge detector register resets to 0.
- INFERENCE_RDY is 0 in every state except STOP.
- NEW_IMAGE never asserts outside LAUNCH.
- IMG_VALID outside IDLE is ignored; no queuing.
- RSTN low mid-operation: immediate return to IDLE with all outputs at reset values. No pending result survives.
- Combinational paths: only IMG_READY depends on an input (ENCODER_RDY). All other outputs are decoded from state or registers.

Optional Feature:
- Macro: ROC_LATENCY_CNT_EN.
- Defined:
  - A 16-bit counter clears on entering LAUNCH and increments every cycle until RESULT is entered.
  - It saturates at 16'hFFFF.
  - Its value on RESULT entry drives RESULT_CYCLES.
- Undefined: RESULT_CYCLES tied to 16'h0 and no counter is inferred. The port exists in both builds.

Decomposition:
- Package roc_pkg holds:
  - typedef enum logic [2:0] roc_ctrl_state_t {IDLE, LAUNCH, ENCODE, STOP, TAIL, RESULT};
  - localparam AER_RST_WORD = 10'h1FF, shared with the encoder.
- One sub-module is natural: roc_event_counter, the rising-edge detector plus saturating index counter.

Test Plan:
- No spike:
  - Stimulus: IMG_VALID with ENCODER_RDY=1; encoder emits 2 reset words then 256 indices; ENCODER_RDY returns; no spike for 4096 cycles.
  - Response: NEW_IMAGE pulses exactly one cycle; RESULT_VALID with TIMEOUT=1, LABEL=0, NIDX=256; INFERENCE_RDY never asserted.
- Early stop:
  - Stimulus: spike ID=7 after 40 indices; ENCODER_RDY rises 6 cycles later.
  - Response: INFERENCE_RDY high for exactly those cycles; LABEL=7, NIDX=40, TIMEOUT=0.
- Late spike in TAIL:
  - Stimulus: full image sent; spike ID=3 at TAIL cycle 100.
  - Response: LABEL=3, TIMEOUT=0, NIDX=256.
- Simultaneous events:
  - Stimulus: (a) spike and ENCODER_RDY rise in the same ENCODE cycle; (b) spike coincides with timeout expiry.
  - Response: (a) direct to RESULT with no STOP cycle; (b) TIMEOUT=0 with the spike's label.
- Handshake and reset:
  - Stimulus: hold RESULT_ACK low 20 cycles; then pulse IMG_VALID while in RESULT; then assert RSTN low during ENCODE.
  - Response: outputs stable for the 20 cycles; IMG_VALID ignored; reset returns all outputs to reset values asynchronously.
- Latency counter:
  - Stimulus: build with ROC_LATENCY_CNT_EN, early stop at cycle 57 after LAUNCH.
  - Response: RESULT_CYCLES matches the cycle count from LAUNCH to RESULT entry.
  - Build without the macro: RESULT_CYCLES reads 0.
